program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32, SHALL be the target program memory capacity in 32-bit words.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the instruction word and address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start_i  input  1  SHALL request a new load session (level sampled each clk).
REQ-006 byte_i  input  8  SHALL carry the serial load stream byte.
REQ-007 byte_valid_i  input  1  SHALL mark byte_i valid.
REQ-008 byte_ready_o  output  1  SHALL indicate the loader accepts byte_i this cycle.
REQ-009 mem_we_o  output  1  SHALL be the program memory write strobe, one cycle per word.
REQ-010 mem_address_o  output  DATA_WIDTH  SHALL be the word-aligned byte address (word index x 4, bits [1:0] = 0).
REQ-011 mem_data_o  output  DATA_WIDTH  SHALL be the assembled instruction word.
REQ-012 cpu_hold_o  output  1  SHALL hold the processor in reset while a session is active.
REQ-013 busy_o / done_o / error_o  output  1 each  SHALL report session active / completed / rejected.

Function
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
REQ-015 A byte transfer SHALL occur only on a cycle with byte_valid_i && byte_ready_o; byte_ready_o high only in LEN_HI, LEN_LO, DATA.
REQ-016 IDLE, DONE, ERROR: start_i=1 -> LEN_HI next cycle; word index and byte counter cleared; done_o/error_o cleared.
REQ-017 Stream format: 16-bit word count N big-endian (LEN_HI then LEN_LO), then N words, 4 bytes each, most-significant byte first.
REQ-018 LEN_LO transfer: N=0 -> DONE; N>MEMORY_DEPTH -> ERROR with no memory write; else -> DATA.
REQ-019 DATA: each transfer shifts byte into the word register; 4th byte -> WRITE.
REQ-020 WRITE: mem_we_o=1 exactly one cycle, mem_address_o = index<<2, mem_data_o = assembled word; index increments; index+1==N -> DONE, else -> DATA.
REQ-021 byte_ready_o SHALL be 0 in WRITE (one-cycle backpressure per word); a byte held valid is accepted the following DATA cycle, never lost or duplicated.
REQ-022 busy_o=1 and cpu_hold_o=1 in LEN_HI, LEN_LO, DATA, WRITE; otherwise 0.
REQ-023 done_o=1 only in DONE; error_o=1 only in ERROR; both sticky until next start_i or reset.
REQ-024 start_i SHALL be ignored while busy_o=1.
REQ-025 mem_we_o SHALL be 0 in every state except WRITE; mem_address_o/mem_data_o hold last values otherwise.
REQ-026 Byte stalls (byte_valid_i low) of any length SHALL not alter state; no timeout.

Reset
REQ-027 reset=1 SHALL force IDLE next edge; all outputs 0; counters, N, word register cleared; dominates start_i and any transfer.
REQ-028 reset mid-session SHALL abort with no further write; already-written words are not rolled back.

Structure
REQ-029 State encoding and the stream header width (16) SHALL live in a shared package, mips_loader_pkg.
REQ-030 Byte-to-word assembly SHALL be a sub-module, word_assembler (shift register + 2-bit byte counter, word_ready pulse).
REQ-031 Memory address arithmetic SHALL use DATA_WIDTH bits; index counter sized $clog2(MEMORY_DEPTH)+1.

Verification
REQ-032 reset, start_i pulse, stream 00 02 20 08 00 05 AC 08 00 00 continuous valid -> writes (0x0,0x20080005),(0x4,0xAC080000), then done_o=1, cpu_hold_o=0.
REQ-033 Header 00 00 -> DONE directly, no mem_we_o, done_o=1.
REQ-034 Header 00 21 with MEMORY_DEPTH=32 -> error_o=1, no writes, byte_ready_o=0.
REQ-035 N=1, byte_valid_i toggled randomly with gaps of 0-5 cycles -> single write (0x0, expected word), byte count exactly 6.
REQ-036 reset asserted after 2nd data byte of word 1 (N=3) -> IDLE next cycle, no write for word 1, all outputs 0; fresh start_i then loads correctly.
REQ-037 start_i held high throughout a 2-word load -> no restart mid-session; re-enters LEN_HI from DONE one cycle after completion.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and stream header width.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int HDR_WIDTH = 16;

endpackage

// File: rtl/word_assembler.sv
// Packs four serial bytes, most-significant first, into a 32-bit word.
// word_ready_o pulses on the cycle the fourth byte is accepted.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (byte_en_i) begin
            r_word <= {r_word[23:0], byte_i};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    assign word_o       = r_word;
    assign word_ready_o = byte_en_i && (r_cnt == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Serial program loader: reads a big-endian word count and that many 32-bit words,
// writes them to program memory and holds the CPU in reset while loading.
module program_loader
    import mips_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH) + 1;
    localparam logic [HDR_WIDTH-1:0] DEPTH_L = HDR_WIDTH'(MEMORY_DEPTH);

    state_t                 r_state;
    state_t                 w_next;
    logic [HDR_WIDTH-1:0]   r_len;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_last_addr;
    logic [DATA_WIDTH-1:0]  r_last_data;

    logic                   w_xfer;
    logic                   w_clear;
    logic [HDR_WIDTH-1:0]   w_len_full;
    logic [IDX_W-1:0]       w_idx_inc;
    logic [DATA_WIDTH-1:0]  w_addr;
    logic [31:0]            w_word;
    logic                   w_word_ready;

    assign w_xfer     = byte_valid_i && byte_ready_o;
    assign w_len_full = {r_len[15:8], byte_i};
    assign w_idx_inc  = r_idx + 1'b1;
    assign w_addr     = DATA_WIDTH'(r_idx) << 2;
    assign cpu_hold_o = busy_o;

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (w_clear),
        .byte_en_i    (w_xfer && (r_state == ST_DATA)),
        .byte_i       (byte_i),
        .word_o       (w_word),
        .word_ready_o (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_idx <= '0;
                r_len <= '0;
            end
            if (r_state == ST_LEN_HI && w_xfer) r_len[15:8] <= byte_i;
            if (r_state == ST_LEN_LO && w_xfer) r_len[7:0]  <= byte_i;
            if (r_state == ST_WRITE) begin
                r_idx       <= w_idx_inc;
                r_last_addr <= w_addr;
                r_last_data <= DATA_WIDTH'(w_word);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_clear       = 1'b0;
        byte_ready_o  = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        error_o       = 1'b0;
        mem_we_o      = 1'b0;
        mem_address_o = r_last_addr;
        mem_data_o    = r_last_data;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                done_o  = (r_state == ST_DONE);
                error_o = (r_state == ST_ERROR);
                if (start_i) begin
                    w_next  = ST_LEN_HI;
                    w_clear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (w_xfer) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (w_xfer) begin
                    if (w_len_full == '0)          w_next = ST_DONE;
                    else if (w_len_full > DEPTH_L) w_next = ST_ERROR;
                    else                           w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (w_word_ready) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy_o        = 1'b1;
                mem_we_o      = 1'b1;
                mem_address_o = w_addr;
                mem_data_o    = DATA_WIDTH'(w_word);
                // Index compared after increment so the last word finishes the session.
                w_next = (HDR_WIDTH'(w_idx_inc) == r_len) ? ST_DONE : ST_DATA;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a stream model predicts memory writes,
// a monitor pops and compares them as mem_we_o strobes.
module tb_program_loader;

    localparam int DEPTH = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_address_o;
    logic [DW-1:0] mem_data_o;
    logic          cpu_hold_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .mem_we_o      (mem_we_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .cpu_hold_o    (cpu_hold_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_bytes  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) if (!reset && byte_valid_i && byte_ready_o) n_bytes++;

    always @(negedge clk) begin
        wr_t e;
        if (mem_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         mem_address_o, mem_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_address_o, e.addr);
                chk("wr_data", mem_data_o, e.data);
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, busy_o},       32'd0);
        chk({tag, "_hold"},  {31'd0, cpu_hold_o},   32'd0);
        chk({tag, "_done"},  {31'd0, done_o},       32'd0);
        chk({tag, "_err"},   {31'd0, error_o},      32'd0);
        chk({tag, "_we"},    {31'd0, mem_we_o},     32'd0);
        chk({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        chk({tag, "_addr"},  mem_address_o,         32'd0);
        chk({tag, "_data"},  mem_data_o,            32'd0);
    endtask

    // Starts and ends at a negedge; holds the byte until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (byte_ready_o) begin
                @(negedge clk);
                byte_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL byte_accept_timeout: byte 0x%0h never accepted", b);
    endtask

    task automatic wait_end();
        for (int t = 0; t < 400; t++) begin
            if (done_o || error_o) return;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL session_timeout: done=%0b error=%0b", done_o, error_o);
    endtask

    // Reference model: an accepted header of N words writes word i at byte address 4*i.
    task automatic predict(input int n, input logic [31:0] words[$]);
        if (n > 0 && n <= DEPTH)
            for (int i = 0; i < n; i++) exp_q.push_back({32'(i * 4), words[i]});
    endtask

    task automatic send_stream(input int n, input logic [31:0] words[$], input int max_gap);
        logic [15:0] len;
        len = 16'(n);
        send_byte(len[15:8], max_gap);
        send_byte(len[7:0],  max_gap);
        if (n > 0 && n <= DEPTH)
            for (int i = 0; i < n; i++)
                for (int k = 3; k >= 0; k--) begin
                    logic [31:0] w;
                    w = words[i];
                    send_byte(w[k*8 +: 8], max_gap);
                end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_load(input string tag, input int n, input logic [31:0] words[$],
                            input int max_gap);
        logic want_err;
        want_err = (n > DEPTH);
        predict(n, words);
        pulse_start();
        send_stream(n, words, max_gap);
        wait_end();
        chk({tag, "_done"},  {31'd0, done_o},       {31'd0, !want_err});
        chk({tag, "_err"},   {31'd0, error_o},      {31'd0, want_err});
        chk({tag, "_hold"},  {31'd0, cpu_hold_o},   32'd0);
        chk({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()),   32'd0);
        exp_q.delete();
    endtask

    function automatic void rand_words(input int n, output logic [31:0] q[$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back($urandom());
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wq[$];
        int          b0;
        reset = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_zero("reset");

        wq = '{32'h2008_0005, 32'hAC08_0000};
        run_load("two_word", 2, wq, 0);

        wq.delete();
        run_load("len_zero", 0, wq, 0);

        run_load("len_over", DEPTH + 1, wq, 0);

        rand_words(1, wq);
        b0 = n_bytes;
        run_load("gapped_one", 1, wq, 5);
        chk("gapped_byte_count", 32'(n_bytes - b0), 32'd6);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 6);
            rand_words(n, wq);
            run_load("rand_load", n, wq, 3);
        end

        rand_words(DEPTH, wq);
        run_load("full_depth", DEPTH, wq, 0);

        // Abort in the middle of word 1: only word 0 may reach memory.
        rand_words(3, wq);
        exp_q.push_back({32'h0, wq[0]});
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int k = 3; k >= 0; k--) send_byte(wq[0][k*8 +: 8], 0);
        send_byte(wq[1][31:24], 0);
        send_byte(wq[1][23:16], 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("abort");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_we", {31'd0, mem_we_o}, 32'd0);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rand_words(2, wq);
        run_load("after_abort", 2, wq, 2);

        // start_i held high for a whole session.
        rand_words(2, wq);
        predict(2, wq);
        start_i = 1'b1;
        @(negedge clk);
        send_stream(2, wq, 1);
        wait_end();
        chk("held_done", {31'd0, done_o}, 32'd1);
        chk("held_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("held_restart_busy", {31'd0, busy_o}, 32'd1);
        chk("held_restart_done", {31'd0, done_o}, 32'd0);
        chk("held_restart_ready", {31'd0, byte_ready_o}, 32'd1);
        start_i = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_q.delete();
        check_idle_zero("final");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
